alu_cmd_driver: RTL and testbench

- Initiator side of the ALU interface: accepts operand/instruction commands from upstream, queues them, and drives the ALU operand and instruction inputs.
- Waits a fixed ALU latency, captures the ALU result and returns it downstream over a valid/ready handshake.
- Sits between a command source (test sequencer or controller) and the N-bit ALU. Exactly one ALU operation is in flight at a time.

---
 rtl/alu_cmd_driver_if.sv | 31 +++
 rtl/alu_cmd_driver.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_driver_if.sv
// Command, ALU and result signal bundle for alu_cmd_driver.
// The master modport is the driver's view; slave is the surrounding environment's view.
interface alu_cmd_driver_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [M-1:0] cmd_instr;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [M-1:0] alu_instr;
  logic [N-1:0] alu_result;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [M-1:0] res_instr;
  logic         busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_instr, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_instr, res_valid, res_data, res_instr, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_instr, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_instr, res_valid, res_data, res_instr, busy
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// ALU initiator: queues commands in a FIFO, issues one ALU op at a time, waits the
// fixed ALU latency, then returns the captured result over a valid/ready handshake.
module alu_cmd_driver #(
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.master bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(ALU_LAT - 1);

  typedef struct packed {
    logic [M-1:0] instr;
    logic [N-1:0] b;
    logic [N-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [N-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [M-1:0]    alu_instr_q, alu_instr_d, res_instr_q, res_instr_d;
  logic            res_valid_q, res_valid_d;
  logic            cmd_ready, push, pop;
  cmd_t            head;

  // Full means no accept, even if the head pops on the same edge.
  assign cmd_ready = (count_q < CntW'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: bus.cmd_instr, b: bus.cmd_b, a: bus.cmd_a};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_instr_d = alu_instr_q;
    res_data_d  = res_data_q;
    res_instr_d = res_instr_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          res_data_d  = bus.alu_result;
          res_instr_d = alu_instr_q;
          res_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StResp: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          // Back-to-back issue: reload the ALU on the handshake edge.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      alu_a_d     = head.a;
      alu_b_d     = head.b;
      alu_instr_d = head.instr;
      lat_d       = LatInit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      lat_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= '0;
      res_data_q  <= '0;
      res_instr_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_instr_q <= alu_instr_d;
      res_data_q  <= res_data_d;
      res_instr_q <= res_instr_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_instr = alu_instr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_instr = res_instr_q;
  assign bus.busy      = (state_q != StIdle) || (count_q != '0);
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a 4-bit ALU model (add when instr[3]=0, AND when 1).
module tb_alu_cmd_driver;
  localparam int unsigned N = 4;
  localparam int unsigned M = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic [11:0] cmds[$];
  int         acc;
  int         seen;
  logic [7:0] snap_res;
  logic [3:0] snap_a, snap_b;

  alu_cmd_driver_if #(.N(N), .M(M)) bus ();

  alu_cmd_driver #(.N(N), .M(M), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ALU evaluates the driver's registered operand ports; result settles one edge after load.
  assign bus.alu_result = bus.alu_instr[3] ? (bus.alu_a & bus.alu_b)
                                           : 4'(bus.alu_a + bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives each {a,b,instr} for one edge with cmd_valid high; counts accepted ones.
  task automatic push_seq(input logic [11:0] c[$], output int n_acc);
    n_acc = 0;
    foreach (c[k]) begin
      bus.cmd_a     = c[k][11:8];
      bus.cmd_b     = c[k][7:4];
      bus.cmd_instr = c[k][3:0];
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) n_acc++;
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
      if (bus.res_valid && bus.res_ready) begin
        check("drain_res", {bus.res_instr, bus.res_data}, exp_q.pop_front());
      end
      tick();
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_instr = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_instr}, 0);
    check("rst_res", {bus.res_data, bus.res_instr}, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_valid", bus.res_valid, 0);

    // Single op: 5+3.
    cmds = '{12'h530};
    push_seq(cmds, acc);
    check("single_busy", bus.busy, 1);
    tick();
    check("single_alu", {bus.alu_a, bus.alu_b, bus.alu_instr}, 12'h530);
    check("single_not_yet", bus.res_valid, 0);
    tick();
    check("single_valid", bus.res_valid, 1);
    check("single_res", {bus.res_instr, bus.res_data}, 8'h08);
    bus.res_ready = 1'b1;
    tick();
    check("single_clear", bus.res_valid, 0);
    check("single_idle", bus.busy, 0);

    // Add wrap then logic AND, res_ready held high.
    cmds = '{12'hF20, 12'hCA8};
    push_seq(cmds, acc);
    tick();
    check("wrap_res", {bus.res_valid, bus.res_instr, bus.res_data}, 9'h101);
    tick();
    check("wrap_gap", bus.res_valid, 0);
    tick();
    check("logic_res", {bus.res_valid, bus.res_instr, bus.res_data}, 9'h188);
    tick();
    check("wrap_idle", {bus.res_valid, bus.busy}, 0);

    // Backpressure: six back-to-back, five fit.
    bus.res_ready = 1'b0;
    cmds = '{12'h120, 12'h340, 12'hFF8, 12'h980, 12'h638, 12'h770};
    push_seq(cmds, acc);
    check("bp_accepted", acc, 5);
    check("bp_full", bus.cmd_ready, 0);
    snap_res = {bus.res_instr, bus.res_data};
    snap_a   = bus.alu_a;
    snap_b   = bus.alu_b;
    check("bp_first", snap_res, 8'h03);
    check("bp_alu", {snap_a, snap_b}, 8'h12);
    repeat (3) tick();
    check("bp_stall_res", {bus.res_valid, bus.res_instr, bus.res_data}, {1'b1, snap_res});
    check("bp_stall_alu", {bus.alu_a, bus.alu_b}, {snap_a, snap_b});
    exp_q = '{8'h07, 8'h8F, 8'h01, 8'h82};
    bus.res_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", bus.cmd_ready, 1);
    drain(40);
    tick();
    check("bp_idle", bus.busy, 0);

    // Push on the same edge as the RESP handshake pop.
    bus.res_ready = 1'b0;
    cmds = '{12'h220, 12'hA58, 12'h880};
    push_seq(cmds, acc);
    check("sim_accepted", acc, 3);
    check("sim_first", {bus.res_valid, bus.res_instr, bus.res_data}, 9'h104);
    check("sim_count_before", dut.count_q, 2);
    bus.cmd_a     = 4'hE;
    bus.cmd_b     = 4'h7;
    bus.cmd_instr = 4'h8;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("sim_count_after", dut.count_q, 2);
    exp_q = '{8'h80, 8'h00, 8'h86};
    drain(40);
    tick();
    check("sim_idle", bus.busy, 0);

    // Async reset while in WAIT with three queued.
    bus.res_ready = 1'b0;
    cmds = '{12'h120, 12'h340, 12'hFF8, 12'h980, 12'h638};
    push_seq(cmds, acc);
    bus.res_ready = 1'b1;
    tick();
    check("ar_busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", bus.res_valid, 0);
    check("ar_cmd_ready", bus.cmd_ready, 1);
    check("ar_busy", bus.busy, 0);
    check("ar_alu", {bus.alu_a, bus.alu_b, bus.alu_instr}, 0);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.res_valid || bus.busy) seen++;
    end
    check("ar_no_stale", seen, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
